// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Main sequencing controller for the multicycle RV32I core. Walks every
//   instruction through FETCH / DECODE / execute / memory / writeback over
//   several clocks and drives the datapath mux selects and write enables.
//   Memory accesses go through a unified ready/valid port and stall the FSM
//   until mem_ready. An unsupported opcode parks the core in a sticky HALT.
//
// Parameters
//   RESET_WAIT  : idle cycles spent in RESET after rst_n deasserts, counted
//                 after the first clock edge out of reset (0..15).
//
// Optional build macro
//   PERF_CNT_EN : adds cycle_cnt / instret_cnt performance counters.
//
// Ports
//   clk        in   core clock
//   rst_n      in   asynchronous active-low reset
//   instr      in   instruction register contents (valid from DECODE on)
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access request
//   memwrite   out  store strobe, qualified by mem_req
//   adrsrc     out  memory address select (0 = PC, 1 = ALU result register)
//   irwrite    out  latch instruction register and oldPC
//   pc_en      out  PC register write enable
//   regwrite   out  register-file write enable
//   resultsrc  out  result mux (00 ALU out reg, 01 read data, 10 ALU result)
//   alusrca    out  ALU A select (00 PC, 01 oldPC, 10 rs1, 11 zero)
//   alusrcb    out  ALU B select (00 rs2, 01 immediate, 10 constant 4)
//   aluop      out  ALU decoder mode (00 add, 01 sub, 10 funct3/funct7)
//   immsrc     out  immediate type, combinational from instr[6:0]
//   halted     out  sticky illegal-opcode indication
//   cycle_cnt  out  (PERF_CNT_EN) clocks spent outside RESET/HALT
//   instret_cnt out (PERF_CNT_EN) retired instructions
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int unsigned RESET_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memwrite,
    output logic        adrsrc,
    output logic        irwrite,
    output logic        pc_en,
    output logic        regwrite,
    output logic [1:0]  resultsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic [2:0]  immsrc,
    output logic        halted
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [3:0] WAIT_CYCLES = 4'(RESET_WAIT);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_LUI,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [6:0]  opcode;
    logic        instr_unused;

    assign opcode = instr[6:0];
    // Only the opcode field steers control; the rest belongs to the datapath.
    assign instr_unused = ^instr[31:7];

    // -------------------------------------------------------------------------
    // State and reset-wait registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore-style outputs. Only irwrite/pc_en in FETCH and
    // pc_en in BEQ depend on inputs; everything else follows the state, so an
    // asynchronous reset drops every request/enable immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_req   = 1'b0;
        memwrite  = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pc_en     = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        halted    = 1'b0;

        unique case (state_q)
            S_RESET: begin
                if (wait_q >= WAIT_CYCLES) begin
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_FETCH: begin
                // PC <= PC + 4 through the ALU while memory returns the word
                mem_req   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // oldPC + imm is precomputed for BEQ
                alusrca = 2'b01;
                alusrcb = 2'b01;
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                // Only load/store reach here; bit 5 separates them.
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                // ALU subtracts for the compare; ALU out reg holds the target
                alusrca = 2'b10;
                aluop   = 2'b01;
                pc_en   = zero;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // Target comes from ALU out reg while the ALU forms oldPC + 4
                // for the link write in ALUWB.
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pc_en   = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
                state_d = S_ALUWB;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Immediate type decode, independent of state
    // -------------------------------------------------------------------------
    always_comb begin
        immsrc = 3'b000;
        unique case (opcode)
            OP_STORE: immsrc = 3'b001;
            OP_BR:    immsrc = 3'b010;
            OP_JAL:   immsrc = 3'b011;
            OP_LUI:   immsrc = 3'b100;
            default:  immsrc = 3'b000;
        endcase
    end

`ifdef PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;
    logic        retire;

    // An instruction retires on the edge that takes its last state to FETCH.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BEQ));

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if ((state_q != S_RESET) && (state_q != S_HALT)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (retire) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    localparam int WAIT = 3;

    // Expected output signature, bit order:
    // {mem_req, memwrite, adrsrc, irwrite, pc_en, regwrite,
    //  resultsrc[1:0], alusrca[1:0], alusrcb[1:0], aluop[1:0], halted}
    localparam logic [14:0] X_RST  = 15'b000000_00_00_00_00_0;
    localparam logic [14:0] X_FW   = 15'b100000_10_00_10_00_0;
    localparam logic [14:0] X_FR   = 15'b100110_10_00_10_00_0;
    localparam logic [14:0] X_DEC  = 15'b000000_00_01_01_00_0;
    localparam logic [14:0] X_MADR = 15'b000000_00_10_01_00_0;
    localparam logic [14:0] X_MRD  = 15'b101000_00_00_00_00_0;
    localparam logic [14:0] X_MWB  = 15'b000001_01_00_00_00_0;
    localparam logic [14:0] X_MWR  = 15'b111000_00_00_00_00_0;
    localparam logic [14:0] X_EXR  = 15'b000000_00_10_00_10_0;
    localparam logic [14:0] X_EXI  = 15'b000000_00_10_01_10_0;
    localparam logic [14:0] X_AWB  = 15'b000001_00_00_00_00_0;
    localparam logic [14:0] X_BEQ0 = 15'b000000_00_10_00_01_0;
    localparam logic [14:0] X_BEQ1 = 15'b000010_00_10_00_01_0;
    localparam logic [14:0] X_JAL  = 15'b000010_00_01_10_00_0;
    localparam logic [14:0] X_LUI  = 15'b000000_00_11_01_00_0;
    localparam logic [14:0] X_HALT = 15'b000000_00_00_00_00_1;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h00002103;
    localparam logic [31:0] I_SW   = 32'h00202223;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_JAL  = 32'h0080006F;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        ready;
        logic [14:0] exp;
        logic [2:0]  imm;
    } row_t;

    typedef struct {
        logic [14:0] exp;
        logic [2:0]  imm;
        string       tag;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, memwrite, adrsrc, irwrite, pc_en, regwrite, halted;
    logic [1:0]  resultsrc, alusrca, alusrcb, aluop;
    logic [2:0]  immsrc;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int total = 0;
    int bad = 0;
    row_t tbl[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.RESET_WAIT(WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .memwrite  (memwrite),
        .adrsrc    (adrsrc),
        .irwrite   (irwrite),
        .pc_en     (pc_en),
        .regwrite  (regwrite),
        .resultsrc (resultsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .immsrc    (immsrc),
        .halted    (halted)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    function automatic logic [14:0] actual();
        return {mem_req, memwrite, adrsrc, irwrite, pc_en, regwrite,
                resultsrc, alusrca, alusrcb, aluop, halted};
    endfunction

    task automatic add(input logic [31:0] i, input logic z, input logic r,
                       input logic [14:0] e, input logic [2:0] m);
        row_t x;
        x.instr = i; x.zero = z; x.ready = r; x.exp = e; x.imm = m;
        tbl.push_back(x);
    endtask

    // Pops one expectation and compares it against the current outputs.
    task automatic check_pop();
        sb_t e;
        logic [14:0] a;
        if (sb.size() == 0) begin
            bad++; total++;
            $display("FAIL scoreboard_empty got=0 want=1");
            return;
        end
        e = sb.pop_front();
        a = actual();
        total++;
        if (a !== e.exp || immsrc !== e.imm) begin
            bad++;
            $display("FAIL %s got=%b/%b want=%b/%b", e.tag, a, immsrc, e.exp, e.imm);
        end else begin
            $display("ok   %s out=%b imm=%b", e.tag, a, immsrc);
        end
    endtask

    // Called at negedge+1: drive one cycle's inputs, check, advance a cycle.
    task automatic apply(input row_t r, input string tag);
        sb_t e;
        instr = r.instr; zero = r.zero; mem_ready = r.ready;
        e.exp = r.exp; e.imm = r.imm; e.tag = tag;
        sb.push_back(e);
        #1;
        check_pop();
        @(negedge clk); #1;
    endtask

    task automatic expect_now(input logic [14:0] x, input string tag);
        sb_t e;
        e.exp = x; e.imm = 3'b000; e.tag = tag;
        sb.push_back(e);
        check_pop();
    endtask

    // Releases reset and counts idle cycles until the first fetch request.
    task automatic release_and_wait(input string tag);
        int idle;
        idle = 0;
        instr = 32'd0; mem_ready = 1'b0; zero = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (mem_req) break;
            idle++;
        end
        total++;
        if (idle != WAIT || !mem_req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, idle, WAIT);
        end else begin
            $display("ok   %s idle=%0d", tag, idle);
        end
    endtask

    initial begin
        // Main program: one row per clock, starting in FETCH.
        add(I_ADDI, 0, 1, X_FR,  3'b000); add(I_ADDI, 0, 1, X_DEC, 3'b000);
        add(I_ADDI, 0, 1, X_EXI, 3'b000); add(I_ADDI, 0, 1, X_AWB, 3'b000);
        add(I_LW, 0, 0, X_FW,  3'b000); add(I_LW, 0, 0, X_FW,  3'b000);
        add(I_LW, 0, 0, X_FW,  3'b000); add(I_LW, 0, 1, X_FR,  3'b000);
        add(I_LW, 0, 1, X_DEC, 3'b000); add(I_LW, 0, 1, X_MADR, 3'b000);
        add(I_LW, 0, 0, X_MRD, 3'b000); add(I_LW, 0, 0, X_MRD, 3'b000);
        add(I_LW, 0, 1, X_MRD, 3'b000); add(I_LW, 0, 1, X_MWB, 3'b000);
        add(I_SW, 0, 1, X_FR,  3'b001); add(I_SW, 0, 1, X_DEC, 3'b001);
        add(I_SW, 0, 1, X_MADR, 3'b001); add(I_SW, 0, 0, X_MWR, 3'b001);
        add(I_SW, 0, 1, X_MWR, 3'b001);
        add(I_BEQ, 1, 1, X_FR, 3'b010); add(I_BEQ, 1, 1, X_DEC, 3'b010);
        add(I_BEQ, 1, 1, X_BEQ1, 3'b010);
        add(I_BEQ, 0, 1, X_FR, 3'b010); add(I_BEQ, 0, 1, X_DEC, 3'b010);
        add(I_BEQ, 0, 1, X_BEQ0, 3'b010);
        add(I_ADD, 0, 1, X_FR,  3'b000); add(I_ADD, 0, 1, X_DEC, 3'b000);
        add(I_ADD, 0, 1, X_EXR, 3'b000); add(I_ADD, 0, 1, X_AWB, 3'b000);
        add(I_JAL, 0, 1, X_FR,  3'b011); add(I_JAL, 0, 1, X_DEC, 3'b011);
        add(I_JAL, 0, 1, X_JAL, 3'b011); add(I_JAL, 0, 1, X_AWB, 3'b011);
        add(I_LUI, 0, 1, X_FR,  3'b100); add(I_LUI, 0, 1, X_DEC, 3'b100);
        add(I_LUI, 0, 1, X_LUI, 3'b100); add(I_LUI, 0, 1, X_AWB, 3'b100);
        add(I_ILL, 0, 1, X_FR,  3'b000); add(I_ILL, 0, 1, X_DEC, 3'b000);
        add(I_ILL, 0, 1, X_HALT, 3'b000);

        // Reset state
        @(negedge clk); #1;
        expect_now(X_RST, "reset_outputs");
        release_and_wait("reset_wait_idle");

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // HALT is absorbing regardless of inputs
        for (int i = 0; i < 100; i++) begin
            row_t r;
            r.instr = I_ILL; r.zero = 1'($urandom_range(1));
            r.ready = 1'($urandom_range(1)); r.exp = X_HALT; r.imm = 3'b000;
            apply(r, $sformatf("halt_hold%0d", i));
        end

        // Asynchronous reset clears halted without a clock edge
        rst_n = 1'b0; #1;
        expect_now(X_RST, "halt_cleared_async");
        @(negedge clk); #1;
        release_and_wait("reset_wait_after_halt");

        // Reset mid-fetch drops mem_req immediately
        mem_ready = 1'b0; #1;
        expect_now(X_FW, "fetch_stalled");
        #2 rst_n = 1'b0; #1;
        expect_now(X_RST, "async_drop_mem_req");
        @(negedge clk); #1;

`ifdef PERF_CNT_EN
        begin
            int exp_cycles;
            release_and_wait("reset_wait_perf");
            tbl.delete();
            add(I_ADDI, 0, 1, X_FR, 3'b000); add(I_ADDI, 0, 1, X_DEC, 3'b000);
            add(I_ADDI, 0, 1, X_EXI, 3'b000); add(I_ADDI, 0, 1, X_AWB, 3'b000);
            add(I_LW, 0, 1, X_FR, 3'b000); add(I_LW, 0, 1, X_DEC, 3'b000);
            add(I_LW, 0, 1, X_MADR, 3'b000); add(I_LW, 0, 1, X_MRD, 3'b000);
            add(I_LW, 0, 1, X_MWB, 3'b000);
            add(I_ADD, 0, 1, X_FR, 3'b000); add(I_ADD, 0, 1, X_DEC, 3'b000);
            add(I_ADD, 0, 1, X_EXR, 3'b000); add(I_ADD, 0, 1, X_AWB, 3'b000);
            add(I_BEQ, 1, 1, X_FR, 3'b010); add(I_BEQ, 1, 1, X_DEC, 3'b010);
            add(I_BEQ, 1, 1, X_BEQ1, 3'b010);
            exp_cycles = 4 + 5 + 4 + 3;
            for (int i = 0; i < tbl.size(); i++) begin
                apply(tbl[i], $sformatf("perf_row%0d", i));
            end
            mem_ready = 1'b0;
            total++;
            if (cycle_cnt !== 32'(exp_cycles)) begin
                bad++;
                $display("FAIL cycle_cnt got=%0d want=%0d", cycle_cnt, exp_cycles);
            end else begin
                $display("ok   cycle_cnt=%0d", cycle_cnt);
            end
            total++;
            if (instret_cnt !== 32'd4) begin
                bad++;
                $display("FAIL instret_cnt got=%0d want=4", instret_cnt);
            end else begin
                $display("ok   instret_cnt=%0d", instret_cnt);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main sequencing controller for the multicycle RV32I core; replaces single-cycle control.
- Walks each instruction through fetch/decode/execute/memory/writeback over several clocks and drives datapath mux selects and enables.
- Stalls on a ready/valid unified instruction/data memory port.
- Enters a sticky halt on an unsupported opcode.

Parameters:
- RESET_WAIT, 0, cycles to idle in RESET state after rst_n deasserts before first FETCH (0..15).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction register contents (valid from DECODE onward).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- memwrite  out  1  store strobe, qualified by mem_req.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- irwrite  out  1  latch instruction register and oldPC.
- pc_en  out  1  PC register write enable.
- regwrite  out  1  register-file write enable.
- resultsrc  out  2  result mux: 00 = ALU out register, 01 = read-data register, 10 = ALU result.
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 data, 11 = zero.
- alusrcb  out  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- aluop  out  2  ALU decoder mode: 00 = add, 01 = sub, 10 = use funct3/funct7.
- immsrc  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U. Combinational from instr[6:0]; I-type when opcode is unknown.
- halted  out  1  sticky illegal-opcode indication.

Behaviour:
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, HALT.
- Reset: async to RESET. All outputs 0 except immsrc, which remains combinational. Wait counter cleared.
- RESET: holds RESET_WAIT cycles, then goes to FETCH.
- FETCH: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - While mem_ready=0: irwrite=0, pc_en=0, stay in FETCH.
  - On mem_ready=1: irwrite=1 and pc_en=1 in the same cycle, then DECODE.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (precompute branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 0110111 → LUI
  - otherwise → HALT
- MEMADR: alusrca=10, alusrcb=01, aluop=00. Load opcode → MEMREAD; store opcode → MEMWRITE.
- MEMREAD: mem_req=1, adrsrc=1; waits for mem_ready, then MEMWB.
- MEMWB: resultsrc=01, regwrite=1, then FETCH.
- MEMWRITE: mem_req=1, adrsrc=1, memwrite=1; held until mem_ready, then FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop=10, then ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=10, then ALUWB.
- ALUWB: resultsrc=00, regwrite=1, then FETCH.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00. pc_en = zero (branch taken); then FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pc_en=1 (target), then ALUWB (writes oldPC+4).
- LUI: alusrca=11, alusrcb=01, aluop=00, then ALUWB.
- HALT: halted=1; all enables 0; absorbing until rst_n.
- Each instruction is exactly one pc_en pulse in FETCH, plus at most one more in BEQ/JAL.
- regwrite, memwrite, irwrite and pc_en are never asserted in the same cycle except irwrite+pc_en in FETCH.
- Reset asserted mid-access drops mem_req immediately (async).
- mem_ready outside a request state is ignored.

Optional Feature:
- PERF_CNT_EN: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every clock not in RESET/HALT.
  - instret_cnt increments on leaving MEMWB, MEMWRITE, ALUWB or BEQ to FETCH.
  - Both wrap 0xFFFFFFFF→0.
- Without the macro these ports and registers do not exist.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready always 1 → FETCH, DECODE, EXECI, ALUWB; regwrite=1 only in cycle 4; next FETCH on cycle 5.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD → mem_req held, irwrite/pc_en single pulse on the ready cycle, regwrite in MEMWB only.
- beq with zero=1 → pc_en pulse in BEQ; with zero=0 → no pc_en in BEQ; both return to FETCH.
- jal (0x0080006F) → pc_en in FETCH and JAL, regwrite in ALUWB, resultsrc=00.
- opcode 0x7F in DECODE → HALT, halted=1 stays set for 100 cycles; rst_n low clears it; with RESET_WAIT=3, first mem_req occurs 3 cycles after release.
- PERF_CNT_EN: 4-instruction program, no stalls → instret_cnt=4, and cycle_cnt equals the summed state counts.
